// File: rtl/scroll_display_pkg.sv
// Shared types for the scrolling seven-segment message engine.
package scroll_display_pkg;

  localparam int unsigned SEG_W_DEF = 7;

  typedef logic [SEG_W_DEF-1:0] seg_t;

  // Active-low segments: all ones is a dark digit.
  localparam seg_t SEG_BLANK = '1;

  typedef enum logic {S_IDLE, S_RUN} state_t;

endpackage

// File: rtl/scroll_step_gen.sv
// Divides accepted step_en pulses by TICK_DIV into single-cycle step pulses.
module scroll_step_gen #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic step_c
);

  localparam int unsigned DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [DW-1:0] div_q;

  assign step_c = en && (div_q == DW'(TICK_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q <= '0;
    end else if (clear || step_c) begin
      div_q <= '0;
    end else if (en) begin
      div_q <= div_q + DW'(1);
    end
  end

endmodule

// File: rtl/scroll_display_ctrl.sv
// Scrolling message engine: message buffer, IDLE/RUN scroll FSM and registered window.
// Optional build macro SCROLL_BOUNCE_EN adds bounce_i for ping-pong scrolling.
module scroll_display_ctrl
  import scroll_display_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 6,
  parameter int unsigned MSG_LEN    = 16,
  parameter int unsigned SEG_W      = 7,
  parameter int unsigned TICK_DIV   = 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            wr_en,
  input  logic [$clog2(MSG_LEN)-1:0]      wr_addr,
  input  logic [SEG_W-1:0]                wr_data,
  input  logic [$clog2(MSG_LEN+1)-1:0]    len_i,
  input  logic                            start,
  input  logic                            stop,
  input  logic                            dir,
  input  logic                            step_en,
`ifdef SCROLL_BOUNCE_EN
  input  logic                            bounce_i,
`endif
  output logic [NUM_DIGITS*SEG_W-1:0]     hex_o,
  output logic [$clog2(MSG_LEN)-1:0]      pos_o,
  output logic                            busy,
  output logic                            wrap_o
);

  localparam int unsigned AW = $clog2(MSG_LEN);
  localparam int unsigned LW = $clog2(MSG_LEN + 1);
  localparam int unsigned IW = $clog2(2 * MSG_LEN);
  localparam int unsigned HW = NUM_DIGITS * SEG_W;

  state_t          state_q, state_nxt;
  logic [AW-1:0]   pos_q, pos_nxt;
  logic [LW-1:0]   len_q, len_nxt, len_clamp;
  logic            wrap_q, wrap_nxt;
  logic            busy_q;
  logic [HW-1:0]   hex_q, win;
  logic [SEG_W-1:0] buf_q [MSG_LEN];
  logic            start_ok, step_c;
  logic [IW-1:0]   pos_inc, len_ext;
  logic [IW-1:0]   idx [NUM_DIGITS];
  logic [IW-1:0]   inc;
`ifdef SCROLL_BOUNCE_EN
  logic            bdir_q, bdir_nxt;
  logic [IW-1:0]   bmax;
`endif

  // stop always wins over a simultaneous start; zero-length starts are ignored.
  assign start_ok  = start && !stop && (len_i != '0);
  assign len_clamp = (len_i > LW'(MSG_LEN)) ? LW'(MSG_LEN) : len_i;
  assign pos_inc   = IW'(pos_q) + IW'(1);
  assign len_ext   = IW'(len_q);

  scroll_step_gen #(.TICK_DIV(TICK_DIV)) u_step_gen (
    .clk    (clk),
    .reset  (reset),
    .clear  (start_ok),
    .en     ((state_q == S_RUN) && step_en),
    .step_c (step_c)
  );

  always_comb begin
    state_nxt = state_q;
    pos_nxt   = pos_q;
    len_nxt   = len_q;
    wrap_nxt  = 1'b0;
`ifdef SCROLL_BOUNCE_EN
    bdir_nxt  = bdir_q;
    bmax      = len_ext - IW'(NUM_DIGITS);
`endif
    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          state_nxt = S_RUN;
          len_nxt   = len_clamp;
          pos_nxt   = '0;
`ifdef SCROLL_BOUNCE_EN
          bdir_nxt  = dir;
`endif
        end
      end
      S_RUN: begin
        if (stop) begin
          state_nxt = S_IDLE;
        end else if (start_ok) begin
          len_nxt   = len_clamp;
          pos_nxt   = '0;
`ifdef SCROLL_BOUNCE_EN
          bdir_nxt  = dir;
`endif
        end else if (step_c) begin
`ifdef SCROLL_BOUNCE_EN
          if (bounce_i) begin
            // Ping-pong over 0..len-NUM_DIGITS; reversal happens on arrival at an end.
            if (len_ext <= IW'(NUM_DIGITS)) begin
              pos_nxt = '0;
            end else if (!bdir_q) begin
              if (IW'(pos_q) >= bmax) begin
                pos_nxt  = pos_q - AW'(1);
                bdir_nxt = 1'b1;
                wrap_nxt = 1'b1;
              end else begin
                pos_nxt = AW'(pos_inc);
                if (pos_inc == bmax) begin
                  bdir_nxt = 1'b1;
                  wrap_nxt = 1'b1;
                end
              end
            end else begin
              if (pos_q == '0) begin
                pos_nxt  = AW'(1);
                bdir_nxt = 1'b0;
                wrap_nxt = 1'b1;
              end else begin
                pos_nxt = pos_q - AW'(1);
                if (pos_q == AW'(1)) begin
                  bdir_nxt = 1'b0;
                  wrap_nxt = 1'b1;
                end
              end
            end
          end else
`endif
          if (!dir) begin
            if (pos_inc >= len_ext) begin
              pos_nxt  = '0;
              wrap_nxt = 1'b1;
            end else begin
              pos_nxt = AW'(pos_inc);
            end
          end else begin
            if (pos_q == '0) begin
              pos_nxt  = AW'(len_q - LW'(1));
              wrap_nxt = 1'b1;
            end else begin
              pos_nxt = pos_q - AW'(1);
            end
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      pos_q   <= '0;
      len_q   <= '0;
      wrap_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef SCROLL_BOUNCE_EN
      bdir_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_nxt;
      pos_q   <= pos_nxt;
      len_q   <= len_nxt;
      wrap_q  <= wrap_nxt;
      busy_q  <= (state_nxt == S_RUN);
`ifdef SCROLL_BOUNCE_EN
      bdir_q  <= bdir_nxt;
`endif
    end
  end

  // Message buffer; addresses beyond MSG_LEN match no entry and are dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(MSG_LEN); i++) buf_q[i] <= '1;
    end else if (wr_en) begin
      for (int i = 0; i < int'(MSG_LEN); i++) begin
        if (wr_addr == AW'(i)) buf_q[i] <= wr_data;
      end
    end
  end

  // Window indices walk rightwards from pos, wrapping with one conditional subtract each.
  always_comb begin
    inc = '0;
    win = '1;
    for (int k = 0; k < int'(NUM_DIGITS); k++) idx[k] = '0;
    idx[NUM_DIGITS-1] = IW'(pos_q);
    for (int k = int'(NUM_DIGITS) - 2; k >= 0; k--) begin
      inc    = idx[k+1] + IW'(1);
      idx[k] = (inc >= len_ext) ? inc - len_ext : inc;
    end
    for (int k = 0; k < int'(NUM_DIGITS); k++) begin
      win[k*SEG_W +: SEG_W] = buf_q[AW'(idx[k])];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hex_q <= '1;
    end else if (len_q != '0) begin
      hex_q <= win;
    end
  end

  assign hex_o  = hex_q;
  assign pos_o  = pos_q;
  assign busy   = busy_q;
  assign wrap_o = wrap_q;

endmodule

// File: tb/tb_scroll_display_ctrl.sv
// Bench for scroll_display_ctrl: two instances (TICK_DIV 1 and 3) against a behavioural model.
`timescale 1ns/1ps
module tb_scroll_display_ctrl;
  import scroll_display_pkg::*;

  localparam int unsigned ND = 6;
  localparam int unsigned ML = 12;
  localparam int unsigned SW = 7;
  localparam int unsigned AW = 4;
  localparam int unsigned LW = 4;
  localparam int unsigned HW = ND * SW;

  localparam logic [SW-1:0] CH_H = 7'h09;
  localparam logic [SW-1:0] CH_E = 7'h06;
  localparam logic [SW-1:0] CH_L = 7'h47;
  localparam logic [SW-1:0] CH_O = 7'h40;
  localparam logic [HW-1:0] BLANK = {ND{SEG_BLANK}};
  localparam logic [HW-1:0] HELLO_WIN = {CH_H, CH_E, CH_L, CH_L, CH_O, CH_H};

  logic clk, reset, wr_en, start, stop, dir, step_en;
  logic [AW-1:0] wr_addr;
  logic [SW-1:0] wr_data;
  logic [LW-1:0] len_i;
`ifdef SCROLL_BOUNCE_EN
  logic bounce_i;
`endif
  logic [HW-1:0] hex_d [2];
  logic [AW-1:0] pos_d [2];
  logic          busy_d [2];
  logic          wrap_d [2];

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  // Behavioural model state
  int            m_pos [2];
  int            m_len [2];
  int            m_div [2];
  bit            m_run [2];
  bit            e_wrap [2];
  logic [HW-1:0] e_hex [2];
  logic [SW-1:0] m_buf [ML];
  logic [SW-1:0] hello [5];

  scroll_display_ctrl #(.NUM_DIGITS(ND), .MSG_LEN(ML), .SEG_W(SW), .TICK_DIV(1)) dut_a (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .len_i(len_i), .start(start), .stop(stop), .dir(dir), .step_en(step_en),
`ifdef SCROLL_BOUNCE_EN
    .bounce_i(bounce_i),
`endif
    .hex_o(hex_d[0]), .pos_o(pos_d[0]), .busy(busy_d[0]), .wrap_o(wrap_d[0])
  );

  scroll_display_ctrl #(.NUM_DIGITS(ND), .MSG_LEN(ML), .SEG_W(SW), .TICK_DIV(3)) dut_b (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .len_i(len_i), .start(start), .stop(stop), .dir(dir), .step_en(step_en),
`ifdef SCROLL_BOUNCE_EN
    .bounce_i(bounce_i),
`endif
    .hex_o(hex_d[1]), .pos_o(pos_d[1]), .busy(busy_d[1]), .wrap_o(wrap_d[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int td(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: window from old pos/buffer, then control, then buffer write.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        m_pos[i] = 0; m_len[i] = 0; m_div[i] = 0; m_run[i] = 0;
        e_wrap[i] = 0; e_hex[i] = BLANK;
      end
      for (int a = 0; a < int'(ML); a++) m_buf[a] = SEG_BLANK;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (m_len[i] != 0)
          for (int k = 0; k < int'(ND); k++)
            e_hex[i][k*SW +: SW] = m_buf[(m_pos[i] + int'(ND) - 1 - k) % m_len[i]];
        e_wrap[i] = 0;
        if (stop) begin
          m_run[i] = 0;
        end else if (start && len_i != 0) begin
          m_run[i] = 1;
          m_len[i] = (int'(len_i) > int'(ML)) ? int'(ML) : int'(len_i);
          m_pos[i] = 0;
          m_div[i] = 0;
        end else if (m_run[i] && step_en) begin
          if (m_div[i] == td(i) - 1) begin
            m_div[i] = 0;
            if (!dir) begin
              m_pos[i]  = (m_pos[i] + 1) % m_len[i];
              e_wrap[i] = (m_pos[i] == 0);
            end else begin
              e_wrap[i] = (m_pos[i] == 0);
              m_pos[i]  = (m_pos[i] + m_len[i] - 1) % m_len[i];
            end
          end else begin
            m_div[i]++;
          end
        end
      end
      if (wr_en && int'(wr_addr) < int'(ML)) m_buf[wr_addr] = wr_data;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("hex%0d", i),  64'(hex_d[i]),  64'(e_hex[i]));
        chk($sformatf("pos%0d", i),  64'(pos_d[i]),  64'(m_pos[i]));
        chk($sformatf("busy%0d", i), 64'(busy_d[i]), 64'(m_run[i]));
        chk($sformatf("wrap%0d", i), 64'(wrap_d[i]), 64'(e_wrap[i]));
      end
    end
  end

  initial begin
    int exp_a [5];
    int exp_b [6];
    hello[0] = CH_H; hello[1] = CH_E; hello[2] = CH_L; hello[3] = CH_L; hello[4] = CH_O;
    exp_a[0] = 1; exp_a[1] = 2; exp_a[2] = 3; exp_a[3] = 4; exp_a[4] = 0;
    exp_b[0] = 0; exp_b[1] = 0; exp_b[2] = 7; exp_b[3] = 7; exp_b[4] = 7; exp_b[5] = 6;
    reset = 1; wr_en = 0; wr_addr = '0; wr_data = '0; len_i = '0;
    start = 0; stop = 0; dir = 0; step_en = 0;
`ifdef SCROLL_BOUNCE_EN
    bounce_i = 0;
`endif
    repeat (2) tick();
    reset = 0;
    chk_en = 1;
    @(negedge clk);
    chk("rst_hex", 64'(hex_d[0]), 64'(BLANK));
    chk("rst_pos", 64'(pos_d[0]), 64'd0);
    chk("rst_busy", 64'(busy_d[0]), 64'd0);

    // HELLO, len 5, left scroll, TICK_DIV 1
    tick();
    for (int j = 0; j < 5; j++) begin
      wr_en = 1; wr_addr = AW'(j); wr_data = hello[j];
      tick();
    end
    wr_en = 0;
    len_i = 4'd5; dir = 0; start = 1;
    tick();
    start = 0;
    @(negedge clk);
    chk("start_busy", 64'(busy_d[0]), 64'd1);
    chk("start_pos", 64'(pos_d[0]), 64'd0);
    step_en = 1;
    for (int s = 0; s < 5; s++) begin
      tick();
      @(negedge clk);
      chk("hello_pos", 64'(pos_d[0]), 64'(exp_a[s]));
      chk("hello_wrap", 64'(wrap_d[0]), 64'(s == 4));
    end
    step_en = 0;
    tick();
    @(negedge clk);
    chk("hello_win", 64'(hex_d[0]), 64'(HELLO_WIN));

    // len 8, right scroll, TICK_DIV 3 instance
    tick();
    len_i = 4'd8; dir = 1; start = 1;
    tick();
    start = 0; step_en = 1;
    for (int s = 0; s < 6; s++) begin
      tick();
      @(negedge clk);
      chk("div3_pos", 64'(pos_d[1]), 64'(exp_b[s]));
      chk("div3_wrap", 64'(wrap_d[1]), 64'(s == 2));
    end
    step_en = 0;

    // start+stop together from RUN, then start with len 0
    tick();
    start = 1; stop = 1; len_i = 4'd3;
    tick();
    start = 0; stop = 0; step_en = 1;
    @(negedge clk);
    chk("ss_busy", 64'(busy_d[1]), 64'd0);
    repeat (3) tick();
    step_en = 0;
    @(negedge clk);
    chk("ss_pos_frozen", 64'(pos_d[1]), 64'd6);
    tick();
    start = 1; len_i = 4'd0;
    tick();
    start = 0;
    @(negedge clk);
    chk("len0_busy", 64'(busy_d[0]), 64'd0);

    // Write into displayed address 0, then an out-of-range address
    tick();
    start = 1; len_i = 4'd8; dir = 0;
    tick();
    start = 0;
    repeat (2) tick();
    wr_en = 1; wr_addr = 4'd0; wr_data = 7'h2A;
    tick();
    wr_en = 0;
    @(negedge clk);
    chk("wr_old", 64'(hex_d[0][HW-1 -: SW]), 64'(CH_H));
    tick();
    @(negedge clk);
    chk("wr_new", 64'(hex_d[0][HW-1 -: SW]), 64'h2A);
    tick();
    wr_en = 1; wr_addr = 4'd13; wr_data = 7'h11;
    tick();
    wr_en = 0;
    repeat (2) tick();
    @(negedge clk);
    chk("wr_oob", 64'(hex_d[0][HW-1 -: SW]), 64'h2A);

    // Randomized phase with occasional asynchronous reset
    for (int c = 0; c < 3000; c++) begin
      tick();
      wr_en   = ($urandom_range(0, 99) < 30);
      wr_addr = AW'($urandom_range(0, 15));
      wr_data = SW'($urandom);
      start   = ($urandom_range(0, 99) < 4);
      len_i   = LW'($urandom_range(0, 12));
      stop    = ($urandom_range(0, 99) < 3);
      dir     = 1'($urandom_range(0, 1));
      step_en = ($urandom_range(0, 99) < 50);
      if ($urandom_range(0, 599) == 0) begin
        reset = 1;
        #1;
        chk("arst_hex", 64'(hex_d[1]), 64'(BLANK));
        chk("arst_pos", 64'(pos_d[1]), 64'd0);
        chk("arst_busy", 64'(busy_d[1]), 64'd0);
        tick();
        reset = 0;
      end
    end
    tick();
    wr_en = 0; start = 0; stop = 0; step_en = 0;

`ifdef SCROLL_BOUNCE_EN
    // Bounce over len 9 with six digits: range 0..3
    chk_en = 0;
    reset = 1;
    tick();
    reset = 0;
    bounce_i = 1; len_i = 4'd9; dir = 0; start = 1;
    tick();
    start = 0; step_en = 1;
    begin
      int bseq [7];
      bseq[0] = 1; bseq[1] = 2; bseq[2] = 3; bseq[3] = 2; bseq[4] = 1; bseq[5] = 0; bseq[6] = 1;
      for (int s = 0; s < 7; s++) begin
        tick();
        @(negedge clk);
        chk("bounce_pos", 64'(pos_d[0]), 64'(bseq[s]));
        chk("bounce_wrap", 64'(wrap_d[0]), 64'(s == 2 || s == 5));
      end
    end
    step_en = 0; bounce_i = 0;
`endif

    chk_en = 0;
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
